// File: rtl/seven_seg_pkg.sv
// Shared constants, segment patterns and state encoding for the seven-segment scan driver.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns, entry 15 (F) first down to entry 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/seven_seg_scan_driver_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed 4-digit common-anode display driver with frame-aligned double buffering,
// an all-off blanking gap on every digit change and optional leading-zero blanking.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int BLANK_CYCLES = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [1:0]  digit_sel,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        value_valid,
  input  logic        lzb_en,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done
);

  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [7:0]  blank_cnt_reg, blank_cnt_next;
  logic [1:0]  prev_sel_reg;
  logic [15:0] shadow_value_reg, active_value_reg;
  logic [3:0]  shadow_dp_reg, active_dp_reg;
  logic        pending_reg;
  logic [3:0]  an_next;
  logic [6:0]  seg_next;
  logic        dp_next;

  logic        change;
  logic        boundary;
  logic [3:0]  nibble [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lead_zero;
  logic [3:0]  sel_nibble;
  logic [6:0]  decoded_seg;

  assign change   = (digit_sel != prev_sel_reg);
  assign boundary = change && (prev_sel_reg == 2'd3) && (digit_sel == 2'd0);

  // A digit counts as a leading zero when it and every more significant nibble are zero;
  // the rightmost digit always shows, so a zero value still reads "0".
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibble[gi] = active_value_reg[4*gi +: 4];
      if (gi == 0) begin : g_first
        assign lead_zero[gi] = 1'b0;
      end else begin : g_upper
        assign lead_zero[gi] = (active_value_reg[15:4*gi] == '0);
      end
    end
  endgenerate

  assign sel_nibble = nibble[prev_sel_reg];

  hex_to_seg u_hex_to_seg (
    .nibble (sel_nibble),
    .seg_n  (decoded_seg)
  );

  // State register, blanking counter and digit-select history.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_reg     <= ST_BLANK;
      blank_cnt_reg <= 8'd0;
      prev_sel_reg  <= 2'd0;
    end else begin
      state_reg     <= state_next;
      blank_cnt_reg <= blank_cnt_next;
      prev_sel_reg  <= digit_sel;
    end
  end

  // Next state: any digit change (re)starts the gap; the gap ends after BLANK_CYCLES cycles.
  always_comb begin
    state_next     = state_reg;
    blank_cnt_next = blank_cnt_reg;
    if (change) begin
      state_next     = ST_BLANK;
      blank_cnt_next = 8'd0;
    end else if (state_reg == ST_BLANK) begin
      blank_cnt_next = blank_cnt_reg + 8'd1;
      if (blank_cnt_reg == BLANK_LAST) begin
        state_next = ST_DRIVE;
      end
    end
  end

  // Output decode for the current state; registered below so outputs are glitch-free.
  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    if (state_reg == ST_DRIVE) begin
      an_next  = ~(4'b0001 << prev_sel_reg);
      seg_next = (lzb_en && lead_zero[prev_sel_reg]) ? SEG_OFF : decoded_seg;
      dp_next  = ~active_dp_reg[prev_sel_reg];
    end
  end

  // Output registers and frame-wrap pulse.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      an_n       <= AN_OFF;
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an_n       <= an_next;
      seg_n      <= seg_next;
      dp_n       <= dp_next;
      frame_done <= boundary;
    end
  end

  // Double buffer: strobes land in shadow; shadow moves to active only on a 3->0 wrap.
  // A strobe coinciding with the wrap is kept pending for the following wrap.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      shadow_value_reg <= 16'd0;
      shadow_dp_reg    <= 4'd0;
      active_value_reg <= 16'd0;
      active_dp_reg    <= 4'd0;
      pending_reg      <= 1'b0;
    end else begin
      if (boundary && pending_reg) begin
        active_value_reg <= shadow_value_reg;
        active_dp_reg    <= shadow_dp_reg;
        pending_reg      <= 1'b0;
      end
      if (value_valid) begin
        shadow_value_reg <= value;
        shadow_dp_reg    <= dp_in;
        pending_reg      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver: directed scenarios plus a randomized run,
// all compared against a behavioural model based on "cycles since the last digit change".
module tb_seven_seg_scan_driver;

  localparam int B = 4;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  digit_sel = 2'd0;
  logic [15:0] value = 16'd0;
  logic [3:0]  dp_in = 4'd0;
  logic        value_valid = 1'b0;
  logic        lzb_en = 1'b0;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;

  seven_seg_scan_driver #(.BLANK_CYCLES(B)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .digit_sel   (digit_sel),
    .value       (value),
    .dp_in       (dp_in),
    .value_valid (value_valid),
    .lzb_en      (lzb_en),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .frame_done  (frame_done)
  );

  always #5 sysclk = ~sysclk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [1:0]  m_prev;
  int          m_since;
  logic [15:0] m_shadow_v, m_active_v;
  logic [3:0]  m_shadow_dp, m_active_dp;
  logic        m_pending;
  logic [12:0] exp_vec;  // {an_n, seg_n, dp_n, frame_done}
  logic [12:0] obs_vec;

  assign obs_vec = {an_n, seg_n, dp_n, frame_done};

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Apply one cycle of inputs, advance the clock and the model, then settle past the edge.
  task automatic tick(input logic rst, input logic [1:0] sel, input logic vv,
                      input logic [15:0] val, input logic [3:0] dp, input logic lzb);
    logic ch, bnd;
    int d;
    reset = rst; digit_sel = sel; value_valid = vv; value = val; dp_in = dp; lzb_en = lzb;
    @(posedge sysclk);
    if (rst) begin
      exp_vec = {4'hF, 7'h7F, 1'b1, 1'b0};
      m_prev = 2'd0; m_since = 0; m_pending = 1'b0;
      m_shadow_v = 16'd0; m_shadow_dp = 4'd0; m_active_v = 16'd0; m_active_dp = 4'd0;
    end else begin
      d = int'(m_prev);
      if (m_since >= B) begin
        exp_vec[12:9] = ~(4'b0001 << d);
        if (lzb && d != 0 && (m_active_v >> (4 * d)) == 16'd0) exp_vec[8:2] = 7'h7F;
        else exp_vec[8:2] = seg_of(m_active_v[4*d +: 4]);
        exp_vec[1] = ~m_active_dp[d];
      end else begin
        exp_vec[12:1] = {4'hF, 7'h7F, 1'b1};
      end
      ch  = (sel != m_prev);
      bnd = ch && (m_prev == 2'd3) && (sel == 2'd0);
      exp_vec[0] = bnd;
      if (bnd && m_pending) begin
        m_active_v = m_shadow_v; m_active_dp = m_shadow_dp; m_pending = 1'b0;
      end
      if (vv) begin
        m_shadow_v = val; m_shadow_dp = dp; m_pending = 1'b1;
      end
      m_since = ch ? 0 : ((m_since < 1000) ? m_since + 1 : m_since);
      m_prev = sel;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 2'd0, 1'b0, 16'd0, 4'd0, 1'b0);
      n_cmp++;
      if (obs_vec !== 13'h1FFE) begin
        n_fail++;
        $display("FAIL reset_hold: got %h want %h", obs_vec, 13'h1FFE);
      end
    end
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 2'd0, 1'b0, 16'd0, 4'd0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_model k=%0d: got %h want %h", k, obs_vec, exp_vec);
      end
      n_cmp++;
      if (k < 4 && an_n !== 4'hF) begin
        n_fail++;
        $display("FAIL reset_dark k=%0d: an_n got %h want F", k, an_n);
      end else if (k == 4 && {an_n, seg_n} !== {4'hE, 7'h40}) begin
        n_fail++;
        $display("FAIL reset_first_digit: got an=%h seg=%h want an=E seg=40", an_n, seg_n);
      end
    end
  endtask

  task automatic test_frame_transfer();
    logic [1:0] seq [7]  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [3:0] an_lit [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_lit [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    int fd_seen = 0;
    tick(1'b0, 2'd0, 1'b1, 16'h12AF, 4'h0, 1'b0);
    for (int p = 0; p < 7; p++) begin
      for (int k = 0; k < 6; k++) begin
        tick(1'b0, seq[p], 1'b0, 16'd0, 4'd0, 1'b0);
        if (frame_done === 1'b1) fd_seen++;
        n_cmp++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL frame_model p=%0d k=%0d: got %h want %h", p, k, obs_vec, exp_vec);
        end
      end
      n_cmp++;
      if (p < 3 && seg_n !== 7'h40) begin
        n_fail++;
        $display("FAIL frame_before_wrap digit=%0d: seg_n got %h want 40", seq[p], seg_n);
      end else if (p >= 3 && {an_n, seg_n} !== {an_lit[seq[p]], seg_lit[seq[p]]}) begin
        n_fail++;
        $display("FAIL frame_after_wrap digit=%0d: got an=%h seg=%h want an=%h seg=%h",
                 seq[p], an_n, seg_n, an_lit[seq[p]], seg_lit[seq[p]]);
      end
    end
    n_cmp++;
    if (fd_seen != 1) begin
      n_fail++;
      $display("FAIL frame_done_count: got %0d want 1", fd_seen);
    end
  endtask

  task automatic test_fast_toggle();
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, ((k / 2) % 2 == 1) ? 2'd2 : 2'd1, 1'b0, 16'd0, 4'd0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL toggle_model k=%0d: got %h want %h", k, obs_vec, exp_vec);
      end
      if (k > 0) begin
        n_cmp++;
        if (an_n !== 4'hF) begin
          n_fail++;
          $display("FAIL toggle_dark k=%0d: an_n got %h want F", k, an_n);
        end
      end
    end
  endtask

  task automatic test_lzb();
    logic [1:0] seq_a [6] = '{2'd3, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [6:0] lit_a [6] = '{7'h00, 7'h40, 7'h7F, 7'h7F, 7'h12, 7'h40};
    logic [1:0] seq_b [7] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    tick(1'b0, 2'd2, 1'b1, 16'h0050, 4'h0, 1'b1);
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 6; k++) begin
        tick(1'b0, seq_a[p], 1'b0, 16'd0, 4'd0, 1'b1);
        n_cmp++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL lzb_model p=%0d k=%0d: got %h want %h", p, k, obs_vec, exp_vec);
        end
      end
      if (p >= 1) begin
        n_cmp++;
        if (seg_n !== lit_a[p]) begin
          n_fail++;
          $display("FAIL lzb_0050 digit=%0d: seg_n got %h want %h", seq_a[p], seg_n, lit_a[p]);
        end
      end
    end
    tick(1'b0, 2'd0, 1'b1, 16'h0000, 4'h0, 1'b1);
    for (int p = 0; p < 7; p++) begin
      for (int k = 0; k < 6; k++) begin
        tick(1'b0, seq_b[p], 1'b0, 16'd0, 4'd0, 1'b1);
        n_cmp++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL lzb_zero_model p=%0d k=%0d: got %h want %h", p, k, obs_vec, exp_vec);
        end
      end
      if (p >= 3) begin
        n_cmp++;
        if (seg_n !== ((seq_b[p] == 2'd0) ? 7'h40 : 7'h7F)) begin
          n_fail++;
          $display("FAIL lzb_zero digit=%0d: seg_n got %h want %h", seq_b[p], seg_n,
                   (seq_b[p] == 2'd0) ? 7'h40 : 7'h7F);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    tick(1'b0, 2'd3, 1'b1, 16'h1111, 4'h0, 1'b0);
    for (int k = 0; k < 5; k++) tick(1'b0, 2'd3, 1'b0, 16'd0, 4'd0, 1'b0);
    tick(1'b0, 2'd0, 1'b1, 16'h2222, 4'h0, 1'b0);
    n_cmp++;
    if (frame_done !== 1'b1 || obs_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL b2b_boundary: got %h want %h", obs_vec, exp_vec);
    end
    for (int k = 0; k < 5; k++) tick(1'b0, 2'd0, 1'b0, 16'd0, 4'd0, 1'b0);
    n_cmp++;
    if (seg_n !== 7'h79) begin
      n_fail++;
      $display("FAIL b2b_first_wrap: seg_n got %h want 79", seg_n);
    end
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 6; k++) begin
        tick(1'b0, seq[p], 1'b0, 16'd0, 4'd0, 1'b0);
        n_cmp++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL b2b_model p=%0d k=%0d: got %h want %h", p, k, obs_vec, exp_vec);
        end
      end
      n_cmp++;
      if (seg_n !== ((p == 3) ? 7'h24 : 7'h79)) begin
        n_fail++;
        $display("FAIL b2b_digit=%0d: seg_n got %h want %h", seq[p], seg_n,
                 (p == 3) ? 7'h24 : 7'h79);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [1:0] seq [3] = '{2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 6; k++) tick(1'b0, 2'd2, 1'b0, 16'd0, 4'd0, 1'b0);
    tick(1'b0, 2'd2, 1'b1, 16'hABCD, 4'hF, 1'b0);
    n_cmp++;
    if (an_n !== 4'hB) begin
      n_fail++;
      $display("FAIL midreset_pre: an_n got %h want B", an_n);
    end
    tick(1'b1, 2'd2, 1'b0, 16'd0, 4'd0, 1'b0);
    n_cmp++;
    if (obs_vec !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h want %h", obs_vec, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 6; k++) begin
        tick(1'b0, seq[p], 1'b0, 16'd0, 4'd0, 1'b0);
        n_cmp++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL midreset_model p=%0d k=%0d: got %h want %h", p, k, obs_vec, exp_vec);
        end
      end
    end
    n_cmp++;
    if ({an_n, seg_n, dp_n} !== {4'hE, 7'h40, 1'b1}) begin
      n_fail++;
      $display("FAIL midreset_pending_cleared: got %h want %h", {an_n, seg_n, dp_n},
               {4'hE, 7'h40, 1'b1});
    end
  endtask

  task automatic test_random();
    logic [1:0]  sel = 2'd0;
    logic        lzb = 1'b0;
    int          hold = 0;
    for (int k = 0; k < 600; k++) begin
      if (hold == 0) begin
        sel  = 2'($urandom_range(0, 3));
        lzb  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end
      hold--;
      tick(1'b0, sel, ($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), lzb);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random_model k=%0d: got %h want %h", k, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_transfer();
    test_fast_toggle();
    test_lzb();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
